// File: rtl/delay_arb_pkg.sv
// Shared types and default constants for the delay-line arbiter.
package delay_arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFire,
        StWait,
        StDone
    } delay_arb_state_e;

    localparam int unsigned DefaultTmo    = 255;
    localparam int unsigned DefaultRstCyc = 2;

endpackage

// File: rtl/delay_sync.sv
// Two-flop synchronizer with synchronous active-high reset to 0.
module delay_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/delay_arb.sv
// Round-robin time-sharing of one asynchronous delay line between N requesters.
// Optional DELAY_ARB_MEASURE_EN adds meas/meas_vld reporting the WAIT cycle count.
module delay_arb
    import delay_arb_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned TMO     = DefaultTmo,
    parameter int unsigned RST_CYC = DefaultRstCyc
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               req,
    output logic [N-1:0]               ack,
    output logic                       err,
    output logic [$clog2(N)-1:0]       gnt_idx,
    output logic                       busy,
    output logic                       dl_i,
    input  logic                       dl_o,
    output logic                       dl_rst
`ifdef DELAY_ARB_MEASURE_EN
    ,
    output logic [$clog2(TMO+1)-1:0]   meas,
    output logic                       meas_vld
`endif
);

    localparam int unsigned IdxW = $clog2(N);
    localparam int unsigned CntW = $clog2(TMO + 1);
    localparam int unsigned RcW  = $clog2(RST_CYC + 1);

    delay_arb_state_e state_d, state_q;

    logic [IdxW-1:0] gnt_d, gnt_q;
    logic [IdxW-1:0] last_d, last_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic [RcW-1:0]  rc_d, rc_q;
    logic [N-1:0]    ack_d, ack_q;
    logic            err_d, err_q;
    logic            dl_i_d, dl_i_q;
`ifdef DELAY_ARB_MEASURE_EN
    logic [CntW-1:0] meas_d, meas_q;
`endif

    logic            line_sync;
    logic [IdxW-1:0] pick;
    logic            pick_vld;
    logic [31:0]     cand;
    logic [IdxW-1:0] cand_idx;

    delay_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (dl_o),
        .q   (line_sync)
    );

    // Search begins one past the previous winner, so a still-asserted req is not favoured.
    always_comb begin
        pick     = last_q;
        pick_vld = 1'b0;
        cand     = '0;
        cand_idx = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand     = (32'(last_q) + k) % N;
            cand_idx = IdxW'(cand);
            if (!pick_vld && req[cand_idx]) begin
                pick     = cand_idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pick_vld) state_d = StClear;
            StClear: if (rc_q == RcW'(RST_CYC)) state_d = StFire;
            StFire:  state_d = StWait;
            StWait:  if (line_sync || cnt_q == CntW'(TMO)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        gnt_d  = gnt_q;
        last_d = last_q;
        cnt_d  = cnt_q;
        rc_d   = rc_q;
        ack_d  = '0;
        err_d  = 1'b0;
        dl_i_d = (state_d == StFire) || (state_d == StWait);
`ifdef DELAY_ARB_MEASURE_EN
        meas_d = meas_q;
`endif
        if (state_q == StIdle && pick_vld) begin
            gnt_d  = pick;
            last_d = pick;
            rc_d   = RcW'(1);
        end
        if (state_q == StClear && rc_q != RcW'(RST_CYC)) begin
            rc_d = rc_q + RcW'(1);
        end
        if (state_q == StFire) begin
            cnt_d = CntW'(1);
        end
        if (state_q == StWait) begin
            if (state_d == StDone) begin
                ack_d[gnt_q] = 1'b1;
                // A returned edge wins even on the final allowed cycle.
                err_d        = !line_sync;
`ifdef DELAY_ARB_MEASURE_EN
                meas_d       = cnt_q;
`endif
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q  <= '0;
            last_q <= IdxW'(N - 1);
            cnt_q  <= '0;
            rc_q   <= '0;
            ack_q  <= '0;
            err_q  <= 1'b0;
            dl_i_q <= 1'b0;
`ifdef DELAY_ARB_MEASURE_EN
            meas_q <= '0;
`endif
        end else begin
            gnt_q  <= gnt_d;
            last_q <= last_d;
            cnt_q  <= cnt_d;
            rc_q   <= rc_d;
            ack_q  <= ack_d;
            err_q  <= err_d;
            dl_i_q <= dl_i_d;
`ifdef DELAY_ARB_MEASURE_EN
            meas_q <= meas_d;
`endif
        end
    end

    always_comb begin
        busy    = (state_q != StIdle);
        dl_rst  = rst || (state_q == StClear);
        dl_i    = dl_i_q;
        ack     = ack_q;
        err     = err_q;
        gnt_idx = gnt_q;
`ifdef DELAY_ARB_MEASURE_EN
        meas     = meas_q;
        meas_vld = |ack_q;
`endif
    end

endmodule

// File: tb/tb_delay_arb.sv
// Self-checking bench for delay_arb: transaction-level model plus directed literal checks.
module tb_delay_arb;

    localparam int N   = 4;
    localparam int TMO = 10;
    localparam int RC  = 2;
    localparam int CW  = $clog2(TMO + 1);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] ack;
    logic         err;
    logic [1:0]   gnt_idx;
    logic         busy;
    logic         dl_i;
    logic         dl_o;
    logic         dl_rst;
`ifdef DELAY_ARB_MEASURE_EN
    logic [CW-1:0] meas;
    logic          meas_vld;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Line model: 0 = fixed delay of line_d cycles, 1 = output tied low, 2 = glitch source.
    int          line_mode = 0;
    int          line_d    = 5;
    logic        glitch    = 1'b0;
    logic [15:0] hist      = '0;

    delay_arb #(
        .N       (N),
        .TMO     (TMO),
        .RST_CYC (RC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ack     (ack),
        .err     (err),
        .gnt_idx (gnt_idx),
        .busy    (busy),
        .dl_i    (dl_i),
        .dl_o    (dl_o),
        .dl_rst  (dl_rst)
`ifdef DELAY_ARB_MEASURE_EN
        ,
        .meas     (meas),
        .meas_vld (meas_vld)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dl_rst) hist <= '0;
        else        hist <= {hist[14:0], dl_i};
    end

    assign dl_o = (line_mode == 0) ? (hist[line_d-1] & ~dl_rst) :
                  (line_mode == 2) ? glitch : 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: mt counts cycles since the grant cycle (-1 = idle); the whole sequence
    // follows from the arithmetic of RC, the WAIT length mm and the winner.
    int mt = -1, mgnt = 0, mlast = N - 1, mm = 0, mmeas = 0;
    bit merr = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                mt = -1; mlast = N - 1; mgnt = 0; mmeas = 0;
            end else if (mt < 0) begin
                if (req != '0) begin
                    int w;
                    w = -1;
                    for (int k = 1; k <= N; k++) begin
                        if (w < 0 && req[(mlast + k) % N]) w = (mlast + k) % N;
                    end
                    mgnt = w; mlast = w; mt = 1;
                    // Edge reaches dl_o after line_d cycles, plus two synchronizer stages.
                    if (line_mode == 0 && line_d + 2 <= TMO) begin
                        mm = line_d + 2; merr = 1'b0;
                    end else begin
                        mm = TMO; merr = 1'b1;
                    end
                end
            end else if (mt == RC + 2 + mm) begin
                mt = -1;
            end else begin
                mt++;
                if (mt == RC + 2 + mm) mmeas = mm;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (chk_en) begin
                bit done;
                done = (mt == RC + 2 + mm);
                chk("busy", busy, mt >= 1);
                chk("dl_rst", dl_rst, rst || (mt >= 1 && mt <= RC));
                chk("dl_i", dl_i, mt >= RC + 1 && mt <= RC + 1 + mm);
                chk("ack", ack, done ? (1 << mgnt) : 0);
                chk("err", err, done && merr);
                chk("gnt_idx", gnt_idx, mgnt);
                chk("ack_onehot", $onehot0(ack), 1);
`ifdef DELAY_ARB_MEASURE_EN
                chk("meas_vld", meas_vld, done);
                chk("meas", meas, mmeas);
`endif
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Called at the negedge of an idle cycle; n is the ack cycle relative to the grant.
    task automatic run_one(input logic [N-1:0] r, output int n, output logic [N-1:0] a,
                           output logic e);
        req = r;
        n   = 0;
        a   = '0;
        e   = 1'b0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (ack != '0) break;
        end
        a   = ack;
        e   = err;
        req = '0;
        if (a == '0) chk("ack_timeout", 0, 1);
    endtask

    int          n;
    logic [N-1:0] a;
    logic        e;
    int          ord[5];
    int          cyc[5];
    int          exp_ord[5] = '{0, 1, 2, 3, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_dl_rst", dl_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_gnt", gnt_idx, 0);
        do_reset();

        // Single request, 5-cycle line: m = 7, ack at cycle 11.
        line_mode = 0; line_d = 5;
        run_one(4'b0001, n, a, e);
        chk("t1_cycle", n, 11);
        chk("t1_ack", a, 4'b0001);
        chk("t1_err", e, 0);
`ifdef DELAY_ARB_MEASURE_EN
        chk("t1_meas", meas, 7);
`endif
        do_reset();

        // All requesting: strict rotation, one full sequence plus an idle cycle apart.
        begin
            int got, cn;
            got = 0; cn = 0;
            req = 4'b1111;
            while (got < 5 && cn < 200) begin
                @(negedge clk);
                cn++;
                if (ack != '0) begin
                    for (int b = 0; b < N; b++) if (ack[b]) ord[got] = b;
                    cyc[got] = cn;
                    got++;
                    if (got == 5) req = '0;
                end
            end
            req = '0;
            chk("t2_count", got, 5);
            for (int i = 0; i < got; i++) chk("t2_order", ord[i], exp_ord[i]);
            for (int i = 1; i < got; i++) chk("t2_gap", cyc[i] - cyc[i-1], 12);
        end
        do_reset();

        // Line never returns: timeout after TMO WAIT cycles.
        line_mode = 1;
        run_one(4'b0001, n, a, e);
        chk("t3_cycle", n, RC + 12);
        chk("t3_ack", a, 4'b0001);
        chk("t3_err", e, 1);
`ifdef DELAY_ARB_MEASURE_EN
        chk("t3_meas", meas, 10);
`endif
        do_reset();

        // Reset during WAIT aborts without ack; held request restarts from CLEAR.
        line_mode = 1;
        req = 4'b0001;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_busy", busy, 0);
        chk("t4_dl_i", dl_i, 0);
        chk("t4_dl_rst", dl_rst, 1);
        chk("t4_ack", ack, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("t4_restart_busy", busy, 1);
        chk("t4_restart_clear", dl_rst, 1);
        n = 1;
        while (n < 60 && ack == '0) begin
            @(negedge clk);
            n++;
        end
        chk("t4_cycle", n, RC + 12);
        chk("t4_ack", ack, 4'b0001);
        req = '0;
        do_reset();

        // req[2] withdrawn mid-WAIT: sequence still completes (line 3 -> m = 5).
        line_mode = 0; line_d = 3;
        fork
            run_one(4'b0100, n, a, e);
            begin
                repeat (6) @(negedge clk);
                req[2] = 1'b0;
            end
        join
        chk("t5_cycle", n, 9);
        chk("t5_ack", a, 4'b0100);
        chk("t5_err", e, 0);
        do_reset();

        // Sub-cycle glitch strictly between clock edges is never sampled: timeout.
        line_mode = 2;
        fork
            run_one(4'b0010, n, a, e);
            begin
                repeat (6) @(negedge clk);
                #1 glitch = 1'b1;
                #2 glitch = 1'b0;
            end
        join
        chk("t6_cycle", n, RC + 12);
        chk("t6_ack", a, 4'b0010);
        chk("t6_err", e, 1);
        do_reset();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
